// File: rtl/ma_host_ctrl.sv
// Request/result sequencer in front of the MA dictionary compressor, with response timeout and sticky full shortcut.
// Optional statistics counters (cnt_ok/cnt_full/cnt_fail) are built when MA_HOST_STATS_EN is defined.
module ma_host_ctrl #(
    parameter int DATA_W  = 80,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [IDX_W-1:0]  req_index,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [IDX_W-1:0]  rsp_index,
    output logic [DATA_W-1:0] rsp_data,
    output logic              full_flag,
    output logic [1:0]        ma_command,
    output logic [DATA_W-1:0] ma_data_in,
    output logic [IDX_W-1:0]  ma_compressed_in,
    input  logic [IDX_W-1:0]  ma_compressed_out,
    input  logic [DATA_W-1:0] ma_decompressed_out,
    input  logic [1:0]        ma_response
`ifdef MA_HOST_STATS_EN
    ,
    output logic [15:0]       cnt_ok,
    output logic [15:0]       cnt_full,
    output logic [15:0]       cnt_fail
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         status_q, status_d;
    logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic [DATA_W-1:0]  rsp_dat_q, rsp_dat_d;
    logic               full_q, full_d;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        index_d   = index_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        rsp_idx_d = rsp_idx_q;
        rsp_dat_d = rsp_dat_q;
        full_d    = full_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    data_d  = req_data;
                    index_d = req_index;
                    // A compress into a known-full dictionary is answered without bothering MA.
                    if (!req_op && full_q) begin
                        state_d   = HOLD;
                        status_d  = 2'b01;
                        rsp_idx_d = '0;
                        rsp_dat_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!op_q && ma_response == 2'b01) begin
                    state_d   = HOLD;
                    status_d  = 2'b00;
                    rsp_idx_d = ma_compressed_out;
                    rsp_dat_d = '0;
                end else if (op_q && ma_response == 2'b10) begin
                    state_d   = HOLD;
                    status_d  = 2'b00;
                    rsp_idx_d = '0;
                    rsp_dat_d = ma_decompressed_out;
                end else if (ma_response == 2'b11) begin
                    state_d   = HOLD;
                    status_d  = op_q ? 2'b10 : 2'b01;
                    rsp_idx_d = '0;
                    rsp_dat_d = '0;
                    if (!op_q) begin
                        full_d = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last waiting cycle: a valid response above takes priority.
                    state_d   = HOLD;
                    status_d  = 2'b11;
                    rsp_idx_d = '0;
                    rsp_dat_d = '0;
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
            cnt_q     <= '0;
            status_q  <= 2'b00;
            rsp_idx_q <= '0;
            rsp_dat_q <= '0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            index_q   <= index_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_dat_q <= rsp_dat_d;
            full_q    <= full_d;
        end
    end

    logic ma_active;
    assign ma_active        = (state_q == ISSUE) || (state_q == WAIT);
    assign req_ready        = (state_q == IDLE);
    assign rsp_valid        = (state_q == HOLD);
    assign rsp_status       = rsp_valid ? status_q : 2'b00;
    assign rsp_index        = rsp_valid ? rsp_idx_q : '0;
    assign rsp_data         = rsp_valid ? rsp_dat_q : '0;
    assign full_flag        = full_q;
    assign ma_command       = (state_q == ISSUE) ? (op_q ? 2'b10 : 2'b01) : 2'b00;
    assign ma_data_in       = ma_active ? data_q : '0;
    assign ma_compressed_in = ma_active ? index_q : '0;

`ifdef MA_HOST_STATS_EN
    logic [15:0] cnt_ok_q, cnt_ok_d;
    logic [15:0] cnt_full_q, cnt_full_d;
    logic [15:0] cnt_fail_q, cnt_fail_d;

    always_comb begin
        cnt_ok_d   = cnt_ok_q;
        cnt_full_d = cnt_full_q;
        cnt_fail_d = cnt_fail_q;
        if (rsp_valid && rsp_ready) begin
            case (status_q)
                2'b00:   cnt_ok_d   = (cnt_ok_q   != 16'hFFFF) ? cnt_ok_q   + 16'd1 : cnt_ok_q;
                2'b01:   cnt_full_d = (cnt_full_q != 16'hFFFF) ? cnt_full_q + 16'd1 : cnt_full_q;
                default: cnt_fail_d = (cnt_fail_q != 16'hFFFF) ? cnt_fail_q + 16'd1 : cnt_fail_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ok_q   <= '0;
            cnt_full_q <= '0;
            cnt_fail_q <= '0;
        end else begin
            cnt_ok_q   <= cnt_ok_d;
            cnt_full_q <= cnt_full_d;
            cnt_fail_q <= cnt_fail_d;
        end
    end

    assign cnt_ok   = cnt_ok_q;
    assign cnt_full = cnt_full_q;
    assign cnt_fail = cnt_fail_q;
`endif

endmodule

// File: tb/tb_ma_host_ctrl.sv
// Randomized bench for ma_host_ctrl: the bench plays both requester and MA, predicting each result from the protocol rules.
module tb_ma_host_ctrl;
    localparam int DATA_W  = 80;
    localparam int IDX_W   = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_op;
    logic [DATA_W-1:0] req_data;
    logic [IDX_W-1:0]  req_index;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_status;
    logic [IDX_W-1:0]  rsp_index;
    logic [DATA_W-1:0] rsp_data;
    logic              full_flag;
    logic [1:0]        ma_command;
    logic [DATA_W-1:0] ma_data_in;
    logic [IDX_W-1:0]  ma_compressed_in;
    logic [IDX_W-1:0]  ma_compressed_out;
    logic [DATA_W-1:0] ma_decompressed_out;
    logic [1:0]        ma_response;
`ifdef MA_HOST_STATS_EN
    logic [15:0]       cnt_ok, cnt_full, cnt_fail;
    int                ok_m, fullc_m, fail_m;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;
    logic full_m;

    ma_host_ctrl #(.DATA_W(DATA_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_index(req_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_index(rsp_index), .rsp_data(rsp_data), .full_flag(full_flag),
        .ma_command(ma_command), .ma_data_in(ma_data_in), .ma_compressed_in(ma_compressed_in),
        .ma_compressed_out(ma_compressed_out), .ma_decompressed_out(ma_decompressed_out),
        .ma_response(ma_response)
`ifdef MA_HOST_STATS_EN
        , .cnt_ok(cnt_ok), .cnt_full(cnt_full), .cnt_fail(cnt_fail)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return DATA_W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic check_stats();
`ifdef MA_HOST_STATS_EN
        chk("cnt_ok", 96'(cnt_ok), 96'(ok_m));
        chk("cnt_full", 96'(cnt_full), 96'(fullc_m));
        chk("cnt_fail", 96'(cnt_fail), 96'(fail_m));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        full_m = 1'b0;
`ifdef MA_HOST_STATS_EN
        ok_m = 0; fullc_m = 0; fail_m = 0;
`endif
        chk("rst_req_ready", 96'(req_ready), 96'(1));
        chk("rst_rsp_valid", 96'(rsp_valid), 96'(0));
        chk("rst_ma_command", 96'(ma_command), 96'(0));
        chk("rst_full_flag", 96'(full_flag), 96'(0));
        chk("rst_rsp_status", 96'(rsp_status), 96'(0));
        chk("rst_ma_data_in", 96'(ma_data_in), 96'(0));
        check_stats();
        reset = 1'b0;
    endtask

    // at: WAIT cycle (0-based) on which MA answers with code; at >= TIMEOUT means MA stays silent.
    task automatic run_txn(input logic op, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] ix,
                           input int at, input logic [1:0] code, input int hold);
        logic [1:0]        exp_st;
        logic [IDX_W-1:0]  exp_ix, co;
        logic [DATA_W-1:0] exp_d, dout;
        int                exp_k, k;
        exp_st = 2'b11; exp_ix = '0; exp_d = '0;
        chk("req_ready_idle", 96'(req_ready), 96'(1));
        req_valid = 1'b1; req_op = op; req_data = d; req_index = ix;
        step();
        req_valid = 1'b0; req_data = rand_data(); req_index = IDX_W'($urandom);
        if (!op && full_m) begin
            exp_st = 2'b01;
            chk("short_ma_command", 96'(ma_command), 96'(0));
            chk("short_rsp_valid", 96'(rsp_valid), 96'(1));
        end else begin
            chk("issue_ma_command", 96'(ma_command), op ? 96'(2) : 96'(1));
            chk("issue_data_in", 96'(ma_data_in), 96'(d));
            chk("issue_index_in", 96'(ma_compressed_in), 96'(ix));
            chk("issue_rsp_valid", 96'(rsp_valid), 96'(0));
            chk("issue_req_ready", 96'(req_ready), 96'(0));
            step();
            exp_k = (at < TIMEOUT) ? at : TIMEOUT - 1;
            for (k = 0; k < TIMEOUT + 4; k++) begin
                co = IDX_W'($urandom);
                dout = rand_data();
                ma_compressed_out = co;
                ma_decompressed_out = dout;
                if (k == at) begin
                    ma_response = code;
                    if (code == 2'b11) begin
                        exp_st = op ? 2'b10 : 2'b01;
                        if (!op) full_m = 1'b1;
                    end else begin
                        exp_st = 2'b00;
                        exp_ix = op ? '0 : co;
                        exp_d  = op ? dout : '0;
                    end
                end else begin
                    ma_response = ($urandom_range(0, 3) == 0) ? (op ? 2'b01 : 2'b10) : 2'b00;
                end
                chk("wait_ma_command", 96'(ma_command), 96'(0));
                chk("wait_data_hold", 96'(ma_data_in), 96'(d));
                step();
                ma_response = 2'b00;
                if (rsp_valid) break;
            end
            chk("rsp_latency", 96'(k), 96'(exp_k));
        end
        chk("hold_rsp_valid", 96'(rsp_valid), 96'(1));
        chk("hold_status", 96'(rsp_status), 96'(exp_st));
        chk("hold_index", 96'(rsp_index), 96'(exp_ix));
        chk("hold_data", 96'(rsp_data), 96'(exp_d));
        chk("hold_req_ready", 96'(req_ready), 96'(0));
        chk("full_flag", 96'(full_flag), 96'(full_m));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("stall_rsp_valid", 96'(rsp_valid), 96'(1));
            chk("stall_status", 96'(rsp_status), 96'(exp_st));
            chk("stall_index", 96'(rsp_index), 96'(exp_ix));
            chk("stall_data", 96'(rsp_data), 96'(exp_d));
            chk("stall_req_ready", 96'(req_ready), 96'(0));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`ifdef MA_HOST_STATS_EN
        if (exp_st == 2'b00) ok_m++;
        else if (exp_st == 2'b01) fullc_m++;
        else fail_m++;
`endif
        chk("done_rsp_valid", 96'(rsp_valid), 96'(0));
        chk("done_req_ready", 96'(req_ready), 96'(1));
        check_stats();
        n_txn++;
        $display("txn %0d op=%0d at=%0d code=%0d status=%0d index=%0h hold=%0d full=%0d",
                 n_txn, op, at, code, exp_st, exp_ix, hold, full_m);
    endtask

    initial begin
        int sel, at;
        logic op;
        logic [1:0] code;
        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_data = '0; req_index = '0;
        rsp_ready = 1'b0; ma_compressed_out = '0; ma_decompressed_out = '0; ma_response = 2'b00;
        full_m = 1'b0;
`ifdef MA_HOST_STATS_EN
        ok_m = 0; fullc_m = 0; fail_m = 0;
`endif
        do_reset();

        // Directed scenarios first, then random traffic.
        run_txn(1'b0, 80'h1, 8'h00, 1, 2'b01, 0);
        run_txn(1'b1, '0, 8'h05, 2, 2'b10, 1);
        run_txn(1'b1, '0, 8'h09, TIMEOUT, 2'b10, 0);
        run_txn(1'b1, '0, 8'h0A, TIMEOUT - 1, 2'b10, 0);
        run_txn(1'b0, 80'h2, 8'h00, 0, 2'b01, 5);
        run_txn(1'b0, 80'h3, 8'h00, 3, 2'b11, 0);
        run_txn(1'b0, 80'h7, 8'h00, 0, 2'b01, 2);
        run_txn(1'b1, '0, 8'h05, 0, 2'b10, 0);

        for (int t = 0; t < 60; t++) begin
            if (t % 15 == 0) do_reset();
            op  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: at = 0;
                1: at = 1;
                2: at = TIMEOUT - 1;
                3: at = TIMEOUT;
                default: at = int'($urandom_range(0, TIMEOUT - 2));
            endcase
            if ($urandom_range(0, 7) == 0) code = 2'b11;
            else code = op ? 2'b10 : 2'b01;
            run_txn(op, rand_data(), IDX_W'($urandom), at, code, int'($urandom_range(0, 3)));
        end

        // Reset while waiting on MA with the full flag set.
        run_txn(1'b0, 80'h5, 8'h00, 0, 2'b11, 0);
        req_valid = 1'b1; req_op = 1'b1; req_index = 8'h11;
        step();
        req_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        full_m = 1'b0;
        chk("midrst_req_ready", 96'(req_ready), 96'(1));
        chk("midrst_rsp_valid", 96'(rsp_valid), 96'(0));
        chk("midrst_full_flag", 96'(full_flag), 96'(0));
        chk("midrst_ma_command", 96'(ma_command), 96'(0));
        reset = 1'b0;
        step();
        chk("postrst_rsp_valid", 96'(rsp_valid), 96'(0));
        chk("postrst_ma_command", 96'(ma_command), 96'(0));

`ifdef MA_HOST_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) run_txn(1'b0, rand_data(), '0, 1, 2'b01, 0);
        run_txn(1'b0, rand_data(), '0, 1, 2'b11, 0);
        run_txn(1'b1, '0, 8'h01, TIMEOUT, 2'b10, 0);
        chk("stats_ok_3", 96'(cnt_ok), 96'(3));
        chk("stats_full_1", 96'(cnt_full), 96'(1));
        chk("stats_fail_1", 96'(cnt_fail), 96'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
